// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// with start/busy/done handshake and registered result outputs.
module bcd_serial_adder #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  invalid
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS) + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic            r_sub;
    logic            r_carry;
    logic            r_inv;
    logic [CW-1:0]   r_idx;

    state_t          w_state_nx;
    logic [W-1:0]    w_a_nx;
    logic [W-1:0]    w_b_nx;
    logic [W-1:0]    w_acc_nx;
    logic            w_sub_nx;
    logic            w_carry_nx;
    logic            w_inv_nx;
    logic [CW-1:0]   w_idx_nx;
    logic            w_busy_nx;
    logic            w_done_nx;
    logic [W-1:0]    w_sum_nx;
    logic            w_cout_nx;
    logic            w_invalid_nx;

    logic            w_any_bad;
    logic [3:0]      w_a_dig;
    logic [3:0]      w_b_dig;
    logic [3:0]      w_b_adj;
    logic [4:0]      w_t;
    logic            w_gt9;
    logic [3:0]      w_digit;
    logic [W-1:0]    w_acc_shift;

    // Any non-decimal nibble in either operand poisons the whole operation.
    always_comb begin
        w_any_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                w_any_bad = 1'b1;
            end
        end
    end

    // Single digit adder; subtraction uses nine's complement of b plus initial carry.
    assign w_a_dig     = r_a[3:0];
    assign w_b_dig     = r_b[3:0];
    assign w_b_adj     = r_sub ? (4'd9 - w_b_dig) : w_b_dig;
    assign w_t         = 5'(w_a_dig) + 5'(w_b_adj) + 5'(r_carry);
    assign w_gt9       = (w_t > 5'd9);
    assign w_digit     = w_gt9 ? 4'(w_t + 5'd6) : w_t[3:0];
    assign w_acc_shift = (r_acc >> 4) | (W'(w_digit) << (W - 4));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_inv   <= 1'b0;
            r_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_acc   <= w_acc_nx;
            r_sub   <= w_sub_nx;
            r_carry <= w_carry_nx;
            r_inv   <= w_inv_nx;
            r_idx   <= w_idx_nx;
            busy    <= w_busy_nx;
            done    <= w_done_nx;
            sum     <= w_sum_nx;
            cout    <= w_cout_nx;
            invalid <= w_invalid_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_a_nx       = r_a;
        w_b_nx       = r_b;
        w_acc_nx     = r_acc;
        w_sub_nx     = r_sub;
        w_carry_nx   = r_carry;
        w_inv_nx     = r_inv;
        w_idx_nx     = r_idx;
        w_busy_nx    = busy;
        w_done_nx    = 1'b0;
        w_sum_nx     = sum;
        w_cout_nx    = cout;
        w_invalid_nx = invalid;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_RUN;
                    w_a_nx     = a;
                    w_b_nx     = b;
                    w_sub_nx   = sub;
                    w_carry_nx = sub;
                    w_inv_nx   = w_any_bad;
                    w_idx_nx   = '0;
                    w_busy_nx  = 1'b1;
                end
            end
            S_RUN: begin
                // Operands shift down so the current digit is always in the low nibble.
                w_a_nx     = r_a >> 4;
                w_b_nx     = r_b >> 4;
                w_acc_nx   = w_acc_shift;
                w_carry_nx = w_gt9;
                if (r_idx == CW'(DIGITS - 1)) begin
                    w_state_nx = S_IDLE;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                    if (r_inv) begin
                        w_sum_nx     = '0;
                        w_cout_nx    = 1'b0;
                        w_invalid_nx = 1'b1;
                    end else begin
                        w_sum_nx     = w_acc_shift;
                        w_cout_nx    = w_gt9;
                        w_invalid_nx = 1'b0;
                    end
                end else begin
                    w_idx_nx = r_idx + CW'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed plan cases plus random operations
// checked against an integer-arithmetic reference model.
module tb_bcd_serial_adder;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic          sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
    logic          invalid;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the held output registers.
    logic [W-1:0]  m_sum;
    logic          m_cout;
    logic          m_inv;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd_val(input logic [W-1:0] x);
        int v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] x);
        bit bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) if (x[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                         output logic [W-1:0] es, output logic ec, output logic ei);
        int av, bv, ten;
        ten = pow10(DIGITS);
        if (has_bad(ta) || has_bad(tb)) begin
            es = '0; ec = 1'b0; ei = 1'b1;
        end else begin
            av = bcd_val(ta);
            bv = bcd_val(tb);
            ei = 1'b0;
            if (!tsub) begin
                ec = (av + bv >= ten);
                es = to_bcd((av + bv) % ten);
            end else begin
                ec = (av >= bv);
                es = to_bcd((av >= bv) ? (av - bv) : (ten + av - bv));
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one operation; poke re-asserts start mid-run, hold leaves start high after done.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                      input bit poke, input bit hold);
        logic [W-1:0] es;
        logic         ec, ei;
        model(ta, tb, tsub, es, ec, ei);
        a = ta; b = tb; sub = tsub; start = 1'b1;
        @(posedge clock); #1;
        chk("busy_e0", 32'(busy), 32'd1);
        chk("done_e0", 32'(done), 32'd0);
        chk("sum_held_e0", 32'(sum), 32'(m_sum));
        if (!hold) start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        for (int k = 1; k <= DIGITS; k++) begin
            if (poke && k == 1) start = 1'b1;
            if (poke && k == 3) start = 1'b0;
            @(posedge clock); #1;
            if (k < DIGITS) begin
                chk("busy_run", 32'(busy), 32'd1);
                chk("done_run", 32'(done), 32'd0);
                chk("sum_held_run", 32'(sum), 32'(m_sum));
            end else begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_end", 32'(busy), 32'd0);
                chk("sum", 32'(sum), 32'(es));
                chk("cout", 32'(cout), 32'(ec));
                chk("invalid", 32'(invalid), 32'(ei));
                m_sum = es; m_cout = ec; m_inv = ei;
            end
        end
        if (!hold) begin
            @(posedge clock); #1;
            chk("done_single", 32'(done), 32'd0);
            chk("busy_after", 32'(busy), 32'd0);
            chk("sum_hold", 32'(sum), 32'(m_sum));
            chk("cout_hold", 32'(cout), 32'(m_cout));
            chk("inv_hold", 32'(invalid), 32'(m_inv));
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        m_sum = '0; m_cout = 1'b0; m_inv = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_inv", 32'(invalid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        op(16'h1234, 16'h8765, 1'b0, 1'b0, 1'b0);
        op(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0);
        op(16'h0958, 16'h0067, 1'b0, 1'b0, 1'b0);
        op(16'h5000, 16'h1234, 1'b1, 1'b0, 1'b0);
        op(16'h0100, 16'h0200, 1'b1, 1'b0, 1'b0);
        op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        op(16'h12A4, 16'h0001, 1'b0, 1'b0, 1'b0);
        op(16'h0042, 16'h0058, 1'b0, 1'b0, 1'b0);

        // Starts during a run are ignored.
        op(16'h2718, 16'h3141, 1'b0, 1'b1, 1'b0);
        // Start held through done: second op accepted on the following edge.
        op(16'h4444, 16'h1111, 1'b1, 1'b0, 1'b1);
        op(16'h0007, 16'h0009, 1'b0, 1'b0, 1'b0);

        // Reset after digit 1 of 4321+1111.
        a = 16'h4321; b = 16'h1111; sub = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        m_sum = '0; m_cout = 1'b0; m_inv = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_inv", 32'(invalid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            chk("abort_nodone", 32'(done), 32'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        op(16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            ra = to_bcd(int'($urandom_range(pow10(DIGITS) - 1, 0)));
            rb = to_bcd(int'($urandom_range(pow10(DIGITS) - 1, 0)));
            if ($urandom_range(7, 0) == 0) ra = W'($urandom);
            if ($urandom_range(7, 0) == 0) rb = W'($urandom);
            op(ra, rb, 1'($urandom), bit'($urandom_range(3, 0) == 0), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
